branch_predict_ctrl: RTL and testbench
======================================

Name: branch_predict_ctrl

Overview:
Controller for a table of 2-bit saturating branch counters, shared between the Fetch predict port and the Execute update port.
- Issues a taken/not-taken prediction for each fetched branch.
- Tracks in-flight predictions in a small FIFO and updates the indexed counter when each branch resolves.
- Detects mispredictions and sequences recovery: flush pulse, FIFO clear, one-cycle quiet period.
- Also sequences table initialisation after reset.

Parameters:
IDX_W, 4, counter-table index width; table holds 2**IDX_W entries, indexed by PCF[IDX_W+1:2]
DEPTH, 4, in-flight FIFO depth (power of two, >=2)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
PCF  in  32  fetch-stage PC
BranchF  in  1  fetch-stage instruction is a conditional branch (predecode)
StallF  in  1  hazard-unit fetch stall; no push while 1
ResolveE  in  1  a branch resolves in Execute this cycle
TakenE  in  1  actual outcome of the resolving branch (1 = taken)
PredictF  out  1  prediction for PCF (counter MSB); 0 whenever state != RUN
MispredictE  out  1  one-cycle pulse: resolved outcome differs from stored prediction
StallBP  out  1  fetch must stall: state == INIT, or FIFO full
ReadyBP  out  1  1 once INIT completes
ErrorBP  out  1  sticky: ResolveE seen with empty FIFO

Behaviour:
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST. Prediction = MSB.
- Saturating update on resolve:
  - taken: +1, saturates at 11
  - not taken: -1, saturates at 00
- FSM states INIT, RUN, RECOVER.
  - Reset drives state=INIT, init pointer=0, FIFO count=0, MispredictE=0, ErrorBP=0.
- INIT:
  - Writes 01 into entry[ptr] each cycle, ptr++.
  - After writing entry 2**IDX_W-1, goes to RUN. Takes exactly 2**IDX_W cycles.
  - During INIT: StallBP=1, ReadyBP=0, PredictF=0, pushes ignored, ResolveE ignored (no update, no ErrorBP).
- RUN:
  - Push {idx, PredictF} when BranchF & !StallF & !StallBP & !MispredictE-condition.
  - PredictF is combinational from the table (old value if same index is written this cycle; write visible next cycle).
- Resolve (RUN or RECOVER) with FIFO non-empty:
  - Pop head.
  - Update entry[head.idx] with TakenE.
  - MispredictE <= (TakenE != head.pred), registered, asserted the following cycle.
- On mispredict detection:
  - FIFO cleared (count=0, pointers reset) at the same edge as the pop; all younger wrong-path entries dropped.
  - State goes to RECOVER for exactly 1 cycle, then RUN.
  - In RECOVER, pushes suppressed and PredictF=0.
- Simultaneous push and pop without mispredict: both occur, count unchanged.
- Simultaneous push and mispredict detection: push discarded.
- Full (count==DEPTH): StallBP=1, no push even if a pop occurs the same cycle.
- ResolveE with empty FIFO in RUN/RECOVER: no update, no pop. ErrorBP <= 1, cleared only by reset.
- reset low mid-operation: immediate return to INIT, FIFO emptied, outputs to reset values; the table is re-initialised.
- ReadyBP = (state != INIT).

Test Plan:
- Reset, IDX_W=4 -> StallBP=1 for exactly 16 cycles, then ReadyBP=1. PredictF=0 for any PCF; all entries read 01.
- PCF=0x40 branch fetched, then resolved TakenE=1, three times:
  - First resolve -> MispredictE pulses once (entry 01->10).
  - Next fetch of 0x40 predicts 1 (10->11); later resolves produce no pulse.
- Four branches pushed with no resolve (DEPTH=4):
  - StallBP=1 and a 5th BranchF is not pushed.
  - A resolve the same cycle pops but StallBP drops only the next cycle.
- Three in flight, oldest mispredicts:
  - MispredictE=1 for one cycle; count=0.
  - RECOVER: one cycle, PredictF=0, push ignored; RUN next cycle.
- ResolveE with empty FIFO -> ErrorBP=1 and remains 1; table unchanged.
- Async reset mid-RUN (count=2, entry 0x10 = 11):
  - FIFO empty, INIT restarts.
  - Entry 0x10 reads 01 after INIT.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
// Branch prediction controller: 2-bit saturating counter table with table init
// sequencing, in-flight prediction FIFO, resolve-time update and mispredict recovery.
module branch_predict_ctrl #(
    parameter int IDX_W = 4,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic        BranchF,
    input  logic        StallF,
    input  logic        ResolveE,
    input  logic        TakenE,
    output logic        PredictF,
    output logic        MispredictE,
    output logic        StallBP,
    output logic        ReadyBP,
    output logic        ErrorBP
);
    localparam int NENT  = 1 << IDX_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] init_ptr_reg;
    logic [PTR_W-1:0] head_reg, tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic             mispredict_reg;
    logic             error_reg;

    logic [1:0]       table_mem [NENT];
    logic [IDX_W-1:0] fifo_idx  [DEPTH];
    logic             fifo_pred [DEPTH];

    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] head_idx;
    logic             head_pred;
    logic [1:0]       head_ctr, head_ctr_next;
    logic             fifo_full, fifo_empty;
    logic             resolve_act, pop, push, mis_det, err_set;
    logic             unused_pcf;

    assign fetch_idx  = PCF[IDX_W+1:2];
    assign unused_pcf = ^{PCF[31:IDX_W+2], PCF[1:0]};

    assign head_idx   = fifo_idx[head_reg];
    assign head_pred  = fifo_pred[head_reg];
    assign head_ctr   = table_mem[head_idx];

    assign fifo_full  = (count_reg == CNT_W'(DEPTH));
    assign fifo_empty = (count_reg == '0);

    // Resolves are ignored entirely while the table is being initialised
    assign resolve_act = ResolveE && (state_reg != INIT);
    assign pop         = resolve_act && !fifo_empty;
    assign mis_det     = pop && (TakenE != head_pred);
    assign err_set     = resolve_act && fifo_empty;

    assign PredictF    = (state_reg == RUN) && table_mem[fetch_idx][1];
    assign StallBP     = (state_reg == INIT) || fifo_full;
    assign ReadyBP     = (state_reg != INIT);
    assign MispredictE = mispredict_reg;
    assign ErrorBP     = error_reg;

    // A push racing a mispredict belongs to the wrong path and is dropped
    assign push = BranchF && !StallF && !StallBP && (state_reg == RUN) && !mis_det;

    always_comb begin
        head_ctr_next = head_ctr;
        if (TakenE) begin
            if (head_ctr != 2'b11) head_ctr_next = head_ctr + 2'b01;
        end else begin
            if (head_ctr != 2'b00) head_ctr_next = head_ctr - 2'b01;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INIT:    if (init_ptr_reg == IDX_W'(NENT - 1)) state_next = RUN;
            RUN:     if (mis_det) state_next = RECOVER;
            RECOVER: state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    // Storage arrays carry no reset; INIT rewrites every counter after reset
    always_ff @(posedge clk) begin
        if (state_reg == INIT) begin
            table_mem[init_ptr_reg] <= 2'b01;
        end else if (pop) begin
            table_mem[head_idx] <= head_ctr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[tail_reg]  <= fetch_idx;
            fifo_pred[tail_reg] <= PredictF;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= INIT;
            init_ptr_reg   <= '0;
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            mispredict_reg <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            mispredict_reg <= mis_det;
            if (state_reg == INIT) init_ptr_reg <= init_ptr_reg + IDX_W'(1);
            if (err_set) error_reg <= 1'b1;
            if (mis_det) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (pop)  head_reg <= head_reg + PTR_W'(1);
                if (push) tail_reg <= tail_reg + PTR_W'(1);
                count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: directed scenarios plus random traffic, all
// checked each cycle against a counter-table/queue reference model.
module tb_branch_predict_ctrl;
    localparam int IDX_W = 4;
    localparam int DEPTH = 4;
    localparam int NENT  = 1 << IDX_W;

    logic        clk;
    logic        reset;
    logic [31:0] PCF;
    logic        BranchF, StallF, ResolveE, TakenE;
    logic        PredictF, MispredictE, StallBP, ReadyBP, ErrorBP;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int idx;
        bit pred;
    } ent_t;

    // Reference model: counters as ints, in-flight branches as a queue,
    // mode 0 = initialising, 1 = running, 2 = recovering
    int   m_tab [NENT];
    ent_t m_q [$];
    int   m_mode;
    int   m_icnt;
    bit   m_mis;
    bit   m_err;

    branch_predict_ctrl #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .PCF         (PCF),
        .BranchF     (BranchF),
        .StallF      (StallF),
        .ResolveE    (ResolveE),
        .TakenE      (TakenE),
        .PredictF    (PredictF),
        .MispredictE (MispredictE),
        .StallBP     (StallBP),
        .ReadyBP     (ReadyBP),
        .ErrorBP     (ErrorBP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp_val);
        n_tests++;
        if (obs !== exp_val) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at t=%0t", tag, obs, exp_val, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_mode = 0;
        m_icnt = 0;
        m_mis  = 1'b0;
        m_err  = 1'b0;
    endtask

    // Called at posedge+1; asserts reset asynchronously mid-cycle
    task automatic do_reset();
        BranchF = 1'b0; StallF = 1'b0; ResolveE = 1'b0; TakenE = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_PredictF", PredictF, 1'b0);
        check("rst_StallBP", StallBP, 1'b1);
        check("rst_ReadyBP", ReadyBP, 1'b0);
        check("rst_MispredictE", MispredictE, 1'b0);
        check("rst_ErrorBP", ErrorBP, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        $display("[TB] reset applied");
    endtask

    // One clock: apply inputs, check outputs at negedge, advance model at posedge
    task automatic cycle(input logic [31:0] pc, input bit br, input bit st,
                         input bit rs, input bit tk);
        bit   e_pred, e_stall, push, nmis, resolve;
        int   idx;
        ent_t h, n;
        PCF = pc; BranchF = br; StallF = st; ResolveE = rs; TakenE = tk;
        @(negedge clk);
        idx     = int'((pc >> 2) % NENT);
        e_pred  = (m_mode == 1) && (m_tab[idx] >= 2);
        e_stall = (m_mode == 0) || (m_q.size() == DEPTH);
        check("PredictF", PredictF, e_pred);
        check("StallBP", StallBP, e_stall);
        check("ReadyBP", ReadyBP, m_mode != 0);
        check("MispredictE", MispredictE, m_mis);
        check("ErrorBP", ErrorBP, m_err);

        nmis    = 1'b0;
        resolve = rs && (m_mode != 0);
        if (resolve && m_q.size() != 0) begin
            h    = m_q.pop_front();
            nmis = (tk != h.pred);
            if (tk) m_tab[h.idx] = (m_tab[h.idx] == 3) ? 3 : m_tab[h.idx] + 1;
            else    m_tab[h.idx] = (m_tab[h.idx] == 0) ? 0 : m_tab[h.idx] - 1;
            $display("[TB] resolve idx=%0d taken=%0b pred=%0b miss=%0b", h.idx, tk, h.pred, nmis);
        end else if (resolve) begin
            m_err = 1'b1;
        end
        push = br && !st && !e_stall && (m_mode == 1) && !nmis;
        if (nmis) m_q.delete();
        if (push) begin
            n.idx  = idx;
            n.pred = e_pred;
            m_q.push_back(n);
        end
        case (m_mode)
            0: begin
                m_tab[m_icnt] = 1;
                m_icnt++;
                if (m_icnt == NENT) m_mode = 1;
            end
            1: if (nmis) m_mode = 2;
            default: m_mode = 1;
        endcase
        m_mis = nmis;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle($urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int guard = 0;
        while (m_q.size() != 0 && guard < 20) begin
            cycle(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
            guard++;
        end
        while (m_mode != 1 && guard < 40) begin
            cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        check("drain_bound", (m_q.size() == 0 && m_mode == 1), 1'b1);
    endtask

    initial begin
        reset = 1'b0; PCF = '0;
        BranchF = 1'b0; StallF = 1'b0; ResolveE = 1'b0; TakenE = 1'b0;
        foreach (m_tab[i]) m_tab[i] = 0;
        model_reset();
        @(posedge clk);
        #1;

        // Init sequence: pushes and resolves during INIT must be ignored
        do_reset();
        for (int i = 0; i < NENT; i++) cycle($urandom, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Same branch trained taken three times
        for (int k = 0; k < 3; k++) begin
            cycle(32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
            cycle(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
            idle(1);
        end
        drain();

        // Fill the FIFO, attempt a fifth push, then pop with a push in the same cycle
        for (int i = 0; i < DEPTH; i++) cycle(32'h100 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(32'h200, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(32'h204, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle(32'h208, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();

        // Three in flight, oldest mispredicts; push in the detect and RECOVER cycles
        for (int i = 0; i < 3; i++) cycle(32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(32'h40, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();

        // Resolve with an empty FIFO sets the sticky error
        cycle(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        cycle(32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();

        // Train PC 0x10 to strongly taken, leave two in flight, reset mid-run
        do_reset();
        idle(NENT);
        for (int k = 0; k < 2; k++) begin
            cycle(32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
            cycle(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
            idle(1);
        end
        cycle(32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(32'h14, 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        idle(NENT);
        cycle(32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cycle({$urandom_range(0, 255), 24'h0} | 32'($urandom_range(0, NENT - 1) << 2),
                      $urandom_range(0, 99) < 50,
                      $urandom_range(0, 99) < 15,
                      $urandom_range(0, 99) < 30,
                      $urandom_range(0, 1) == 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
